// File: rtl/uart_tx.sv
// UART transmitter with a 4-entry byte FIFO, programmable bit period and LSB-first framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_en,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic [31:0] clk_count_bit,
  output logic        tx,
  output logic        full,
  output logic        busy,
  output logic        end_flag
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        end_flag_q, end_flag_d;

  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;

  logic [31:0] period;
  logic        bit_done;
  logic        push;
  logic        pop;
  logic        can_start;

  // A period of 0 or 1 both mean one clock per bit.
  assign period    = (clk_count_bit <= 32'd1) ? 32'd1 : clk_count_bit;
  assign bit_done  = (cnt_q == period - 32'd1);
  assign push      = wr_en && (count_q != 3'd4);
  assign can_start = tx_en && (count_q != 3'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    end_flag_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (can_start) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d     = 32'd0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d     = 32'd0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          cnt_d   = 32'd0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          cnt_d      = 32'd0;
          end_flag_d = 1'b1;
          bit_idx_d  = 3'd0;
          // Chain straight into the next frame when more data is waiting.
          if (can_start) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = 32'd0;
        state_d = IDLE;
      end
    endcase

    // The line is registered, so it is driven from where the FSM is heading.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^data_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      bit_idx_q  <= 3'd0;
      data_q     <= 8'd0;
      tx_q       <= 1'b1;
      end_flag_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      end_flag_q <= end_flag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign tx       = tx_q;
  assign full     = (count_q == 3'd4);
  assign busy     = (state_q != IDLE);
  assign end_flag = end_flag_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random traffic against a frame-level model.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_en;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [31:0] clk_count_bit;
  logic        tx;
  logic        full;
  logic        busy;
  logic        end_flag;

  int tests = 0;
  int fails = 0;
  int endSeen = 0;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Model: a queue of pending bytes and a position (in clocks) within the frame on the wire.
  logic [7:0] mQueue[$];
  bit         mActive = 1'b0;
  int         mPos = 0;
  logic [7:0] mCur = 8'd0;
  logic       expTx = 1'b1;
  logic       expBusy = 1'b0;
  logic       expEnd = 1'b0;
  logic       expFull = 1'b0;

  uart_tx dut (
    .clk           (clk),
    .reset         (reset),
    .tx_en         (tx_en),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .clk_count_bit (clk_count_bit),
    .tx            (tx),
    .full          (full),
    .busy          (busy),
    .end_flag      (end_flag)
  );

  always #5 clk = ~clk;

  function automatic logic frameBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic modelStep();
    int  p;
    bit  fullBefore;
    bit  ending;
    bit  canStart;
    p = (clk_count_bit <= 32'd1) ? 1 : int'(clk_count_bit);
    if (reset) begin
      mQueue.delete();
      mActive = 1'b0;
      mPos    = 0;
      expTx   = 1'b1;
      expBusy = 1'b0;
      expEnd  = 1'b0;
      expFull = 1'b0;
      return;
    end
    fullBefore = (mQueue.size() == 4);
    ending     = mActive && (mPos == FRAME_BITS * p - 1);
    canStart   = (!mActive || ending) && tx_en && (mQueue.size() > 0);
    if (canStart) begin
      mCur    = mQueue.pop_front();
      mActive = 1'b1;
      mPos    = 0;
    end else if (ending) begin
      mActive = 1'b0;
      mPos    = 0;
    end else if (mActive) begin
      mPos++;
    end
    if (wr_en && !fullBefore) mQueue.push_back(wr_data);
    expTx   = mActive ? frameBit(mCur, mPos / p) : 1'b1;
    expBusy = mActive;
    expEnd  = ending;
    expFull = (mQueue.size() == 4);
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("tx", tx, expTx);
    checkOutput("busy", busy, expBusy);
    checkOutput("end_flag", end_flag, expEnd);
    checkOutput("full", full, expFull);
    if (end_flag === 1'b1) endSeen++;
  endtask

  task automatic applyStimulus(input logic r, input logic te, input logic we,
                               input logic [7:0] d, input int p);
    reset         = r;
    tx_en         = te;
    wr_en         = we;
    wr_data       = d;
    clk_count_bit = 32'(p);
    tick();
  endtask

  task automatic waitIdle(input int limit, input int p);
    int n = 0;
    while ((mActive || (mQueue.size() > 0)) && n < limit) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, p);
      n++;
    end
    tests++;
    assert (n < limit) else begin
      fails++;
      $error("[TB] FAIL idle_timeout: observed %0d cycles expected under %0d", n, limit);
    end
  endtask

  initial begin
    int p;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4);

    // Single 0xA5 frame at four clocks per bit.
    endSeen = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 4);
    waitIdle(200, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 4);
    checkCount("a5_end_pulses", endSeen, 1);

    // Three back-to-back frames with no idle gap.
    endSeen = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, 3);
    waitIdle(300, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 3);
    checkCount("b2b_end_pulses", endSeen, 3);

    // Fill with tx_en low: fifth write is dropped, then exactly four frames.
    endSeen = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h11, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h22, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h33, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h44, 2);
    checkOutput("full_after_4", full, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 2);
    waitIdle(400, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 2);
    checkCount("fill_end_pulses", endSeen, 4);

    // Reset during data bit 3 of 0x3C kills the frame and the queue.
    endSeen = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h99, 2);
    for (int i = 0; i < 100 && !(mActive && (mPos / 2) == 4); i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 2);
    checkCount("reached_data_bit3", mPos / 2, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2);
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_full", full, 1'b0);
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 2);
    checkCount("rst_no_frames", endSeen, 0);

    // One clock per bit, including the degenerate zero period.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h81, 1);
    waitIdle(50, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A, 0);
    waitIdle(50, 0);

    // Odd and even parity bytes.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h07, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h03, 2);
    waitIdle(100, 2);

    // Random traffic; the period only changes while nothing is on the wire.
    p = 3;
    for (int i = 0; i < 1500; i++) begin
      if (!mActive && $urandom_range(0, 3) == 0) p = $urandom_range(0, 5);
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 2) == 0, 8'($urandom), p);
    end
    waitIdle(400, p);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: tx_en  input  1  transmit enable; frame may start only while high.
REQ-004 SHALL have port: wr_en  input  1  write strobe into transmit FIFO.
REQ-005 SHALL have port: wr_data  input  8  byte to enqueue.
REQ-006 SHALL have port: clk_count_bit  input  32  clocks per serial bit.
REQ-007 SHALL have port: tx  output  1  serial line, idle high, registered.
REQ-008 SHALL have port: full  output  1  FIFO holds 4 entries.
REQ-009 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port: end_flag  output  1  one-cycle pulse per completed frame.

Function
REQ-011 SHALL contain a 4-entry, 8-bit FIFO; 2-bit read/write pointers wrap 3->0; 3-bit occupancy count 0..4.
REQ-012 SHALL enqueue wr_data when wr_en=1 and full=0; wr_en while full SHALL be dropped, FIFO unchanged, even if a pop occurs the same cycle.
REQ-013 SHALL allow simultaneous push and pop when not full; occupancy unchanged.
REQ-014 SHALL use states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 IDLE: if tx_en=1 and FIFO non-empty, SHALL pop head into shift register, go to START; tx low from the next cycle.
REQ-016 Each state SHALL last exactly clk_count_bit cycles; 32-bit counter resets to 0 on entry; bit ends when counter == clk_count_bit-1; clk_count_bit 0 or 1 SHALL be treated as 1.
REQ-017 START: tx=0; then DATA.
REQ-018 DATA: 8 bits LSB first; 3-bit bit index; after bit 7 go to PARITY if compiled in, else STOP.
REQ-019 STOP: tx=1 for one bit period; end_flag=1 on the cycle after the last STOP cycle.
REQ-020 At STOP end, if tx_en=1 and FIFO non-empty, SHALL pop and enter START directly (no idle cycle); else IDLE.
REQ-021 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-022 clk_count_bit SHALL be sampled each cycle; changing it mid-frame is unsupported.
REQ-023 full SHALL derive from registered occupancy (==4).

Reset
REQ-024 On reset: tx=1, busy=0, end_flag=0, full=0, state IDLE, counter 0, bit index 0, pointers 0, occupancy 0.
REQ-025 Reset mid-frame SHALL return tx high on the next edge and discard all FIFO contents.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA, tx = XOR of the 8 data bits (even parity), frame 11 bits.
REQ-027 Macro undefined: no PARITY state or logic, frame 10 bits (start, 8 data, stop).

Verification
REQ-028 clk_count_bit=4, write 0xA5, tx_en=1 -> tx: 0 for 4 clks, then 1,0,1,0,0,1,0,1 at 4 clks each, then 1 for 4; end_flag single pulse; busy low after.
REQ-029 Write 0x00,0xFF,0x55 back-to-back, clk_count_bit=3 -> three contiguous 30-clock frames (33 with parity), no idle gap, three end_flag pulses.
REQ-030 tx_en=0, write 5 bytes -> full=1 after 4th, 5th dropped; tx_en=1 -> exactly 4 frames in write order.
REQ-031 Assert reset at DATA bit 3 of 0x3C -> tx=1 next cycle, busy=0, full=0, no end_flag, no further frames.
REQ-032 UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0.
REQ-033 clk_count_bit=1, send 0x81 -> one clock per bit: 0,1,0,0,0,0,0,0,1,1.
